// File: rtl/unpad_pkg.sv
// Shared widths, FSM state type and parameter sanity helper for the unpadder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package unpad_pkg;
  localparam int PIX_W  = 8;
  localparam int SRC_AW = 15;
  localparam int DST_AW = 14;
  localparam int CSUM_W = 16;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // True when the whole padded frame is addressable by the source bus.
  function automatic bit src_fits(input int n, input int pad);
    int w;
    w = n + 2 * pad;
    return (w * w) <= (1 << SRC_AW);
  endfunction
endpackage

// File: rtl/unpadder_if.sv
// Bundle of the unpadder control, source-read and destination-write signals.
// Latency: n/a (wiring only). master = unpadder side, slave = BRAM/control side.
// Backpressure: none; BRAMs are assumed always ready. Optional checksum with UNPADDER_CHECKSUM_EN.
interface unpadder_if;
  import unpad_pkg::*;

  logic              go;
  logic              done;
  logic              ena_src;
  logic [SRC_AW-1:0] addr_src;
  logic [PIX_W-1:0]  dout_src;
  logic              ena_dst;
  logic              wea_dst;
  logic [DST_AW-1:0] addr_dst;
  logic [PIX_W-1:0]  din_dst;
`ifdef UNPADDER_CHECKSUM_EN
  logic [CSUM_W-1:0] checksum;
`endif

  modport master (
    input  go, dout_src,
    output done, ena_src, addr_src, ena_dst, wea_dst, addr_dst, din_dst
`ifdef UNPADDER_CHECKSUM_EN
    , output checksum
`endif
  );

  modport slave (
    output go, dout_src,
    input  done, ena_src, addr_src, ena_dst, wea_dst, addr_dst, din_dst
`ifdef UNPADDER_CHECKSUM_EN
    , input checksum
`endif
  );
endinterface

// File: rtl/unpad_addr_gen.sv
// Walks the N x N interior of the padded frame: source address, destination index, last flag.
// Latency: outputs come straight from registers; one step per i_step cycle.
// Backpressure: holds while i_step is low; i_clr has priority and rewinds to pixel 0.
// Ports: clk, rst_n, i_clr, i_step -> o_src_addr, o_dst_idx, o_last.
module unpad_addr_gen
  import unpad_pkg::*;
#(
  parameter int N   = 16,
  parameter int PAD = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_step,
  output logic [SRC_AW-1:0] o_src_addr,
  output logic [DST_AW-1:0] o_dst_idx,
  output logic              o_last
);
  localparam int W     = N + 2 * PAD;
  localparam int COL_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [SRC_AW-1:0] BASE0    = SRC_AW'(PAD * W + PAD);
  localparam logic [SRC_AW-1:0] ROW_STEP = SRC_AW'(W);
  localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(N - 1);
  localparam logic [DST_AW-1:0] IDX_MAX  = DST_AW'(N * N - 1);

  logic [SRC_AW-1:0] r_base;
  logic [COL_W-1:0]  r_col;
  logic [DST_AW-1:0] r_idx;

  // Row base jumps a whole padded row on column wrap, so no multiply or divide is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base <= BASE0;
      r_col  <= '0;
      r_idx  <= '0;
    end else if (i_clr) begin
      r_base <= BASE0;
      r_col  <= '0;
      r_idx  <= '0;
    end else if (i_step) begin
      r_idx <= r_idx + DST_AW'(1);
      if (r_col == COL_MAX) begin
        r_col  <= '0;
        r_base <= r_base + ROW_STEP;
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  assign o_src_addr = r_base + SRC_AW'(r_col);
  assign o_dst_idx  = r_idx;
  assign o_last     = (r_idx == IDX_MAX);
endmodule

// File: rtl/unpadder.sv
// Crops the N x N interior of a PAD-bordered frame from a source BRAM into a destination BRAM.
// Latency: pixel k read in RUN cycle k, written RD_LAT cycles later; done one cycle after last write.
// Backpressure: none; go low in RUN/DRAIN aborts and flushes. Optional checksum with UNPADDER_CHECKSUM_EN.
// Ports: clk, rst_n (async, active-low), bus (unpadder_if.master).
module unpadder
  import unpad_pkg::*;
#(
  parameter int N      = 16,
  parameter int PAD    = 2,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  unpadder_if.master  bus
);
  if (!src_fits(N, PAD)) begin : g_bad_size
    $error("unpadder: (N+2*PAD)^2 exceeds the source address space");
  end
  if (N < 1 || N > 128) begin : g_bad_n
    $error("unpadder: N must be in 1..128");
  end
  if (RD_LAT < 1 || RD_LAT > 2) begin : g_bad_lat
    $error("unpadder: RD_LAT must be 1 or 2");
  end

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_drain_cnt;
  logic              w_clr;
  logic              w_step;
  logic              w_flush;
  logic              w_issue;
  logic              w_start;
  logic              w_last;
  logic [SRC_AW-1:0] w_src_addr;
  logic [DST_AW-1:0] w_dst_idx;

  logic [RD_LAT-1:0] r_vld;
  logic [DST_AW-1:0] r_idx_pipe [RD_LAT];

  unpad_addr_gen #(.N(N), .PAD(PAD)) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_clr),
    .i_step    (w_step),
    .o_src_addr(w_src_addr),
    .o_dst_idx (w_dst_idx),
    .o_last    (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_step      = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      IDLE: begin
        w_clr = 1'b1;
        if (bus.go) w_state_nxt = RUN;
      end
      RUN: begin
        if (!bus.go) begin
          w_state_nxt = IDLE;
          w_flush     = 1'b1;
        end else begin
          w_step = 1'b1;
          if (w_last) w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!bus.go) begin
          w_state_nxt = IDLE;
          w_flush     = 1'b1;
        end else if (r_drain_cnt == 2'(RD_LAT - 1)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        // Only a low go re-arms; a held go keeps the result parked here.
        if (!bus.go) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A read abandoned by a dropping go never enters the pipeline.
  assign w_issue = (r_state == RUN) && bus.go;
  assign w_start = (r_state == IDLE) && bus.go;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drain_cnt <= '0;
    end else if (r_state == DRAIN) begin
      r_drain_cnt <= r_drain_cnt + 2'd1;
    end else begin
      r_drain_cnt <= '0;
    end
  end

  // Valid bit and destination index ride alongside the BRAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) r_idx_pipe[i] <= '0;
    end else if (w_flush) begin
      r_vld <= '0;
    end else begin
      r_vld[0]      <= w_issue;
      r_idx_pipe[0] <= w_dst_idx;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i]      <= r_vld[i-1];
        r_idx_pipe[i] <= r_idx_pipe[i-1];
      end
    end
  end

  assign bus.ena_src  = (r_state == RUN);
  assign bus.addr_src = (r_state == RUN) ? w_src_addr : '0;
  assign bus.wea_dst  = r_vld[RD_LAT-1];
  assign bus.ena_dst  = r_vld[RD_LAT-1];
  assign bus.addr_dst = r_idx_pipe[RD_LAT-1];
  assign bus.din_dst  = bus.dout_src;
  assign bus.done     = (r_state == DONE);

`ifdef UNPADDER_CHECKSUM_EN
  logic [CSUM_W-1:0] r_checksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checksum <= '0;
    end else if (w_start) begin
      r_checksum <= '0;
    end else if (r_vld[RD_LAT-1]) begin
      r_checksum <= r_checksum + CSUM_W'(bus.dout_src);
    end
  end

  assign bus.checksum = r_checksum;
`endif
endmodule

// File: tb/tb_unpadder.sv
`timescale 1ns/1ps
module tb_unpadder;
  localparam int NI  = 3;
  localparam int PAD = 2;

  // Instance 0: N=4 RD_LAT=1, instance 1: N=4 RD_LAT=2, instance 2: N=16 RD_LAT=1.
  function automatic int n_of(input int g);
    return (g == 2) ? 16 : 4;
  endfunction
  function automatic int l_of(input int g);
    return (g == 1) ? 2 : 1;
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  src_mem [32768];
  logic [7:0]  dst_mem [NI][16384];
  int          wr_cyc  [NI][16384];
  int          wr_cnt  [NI];
  int          ena_cnt [NI];
  int          last_wr [NI];

  logic        go_v      [NI];
  logic        done_v    [NI];
  logic        ena_src_v [NI];
  logic [14:0] addr_src_v[NI];
  logic        ena_dst_v [NI];
  logic        wea_v     [NI];
  logic [13:0] addr_dst_v[NI];
  logic [7:0]  din_v     [NI];
`ifdef UNPADDER_CHECKSUM_EN
  logic [15:0] csum_v    [NI];
`endif

  for (genvar g = 0; g < NI; g++) begin : g_dut
    unpadder_if bi();
    logic [7:0] rd1;
    logic [7:0] rd2;

    unpadder #(.N(n_of(g)), .PAD(PAD), .RD_LAT(l_of(g))) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bi)
    );

    // Source BRAM: registered read, optional second output register.
    always @(posedge clk) begin
      if (bi.ena_src) rd1 <= src_mem[bi.addr_src];
      rd2 <= rd1;
    end

    assign bi.go         = go_v[g];
    assign bi.dout_src   = (l_of(g) == 2) ? rd2 : rd1;
    assign done_v[g]     = bi.done;
    assign ena_src_v[g]  = bi.ena_src;
    assign addr_src_v[g] = bi.addr_src;
    assign ena_dst_v[g]  = bi.ena_dst;
    assign wea_v[g]      = bi.wea_dst;
    assign addr_dst_v[g] = bi.addr_dst;
    assign din_v[g]      = bi.din_dst;
`ifdef UNPADDER_CHECKSUM_EN
    assign csum_v[g]     = bi.checksum;
`endif
  end

  // Destination BRAM plus activity log; values sampled here belong to cycle 'cyc'.
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (ena_src_v[g]) ena_cnt[g]++;
      if (ena_dst_v[g] && wea_v[g]) begin
        dst_mem[g][addr_dst_v[g]] = din_v[g];
        wr_cyc[g][addr_dst_v[g]]  = cyc;
        wr_cnt[g]++;
        last_wr[g] = cyc;
      end
    end
  end

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int c0      [NI];
  int wr_base [NI];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference pixel for interior index k, straight from the crop definition.
  function automatic logic [7:0] ref_pix(input int g, input int k);
    int n, w;
    n = n_of(g);
    w = n + 2 * PAD;
    return src_mem[(k / n + PAD) * w + (k % n) + PAD];
  endfunction

  // Called #1 after an edge with the DUT idle; returns inside cycle 0.
  task automatic start_frame(input int g);
    wr_base[g] = wr_cnt[g];
    go_v[g] = 1'b1;
    @(posedge clk); #1;
    c0[g] = cyc;
  endtask

  task automatic wait_done(input int g, input string tag, input int exp_cyc);
    bit ok;
    int d;
    ok = 0;
    d  = -1;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(posedge clk); #1;
      if (done_v[g]) begin
        ok = 1;
        d  = cyc - c0[g];
      end
    end
    check({tag, "_done_seen"}, ok, 1);
    check({tag, "_done_cyc"}, d, exp_cyc);
  endtask

  task automatic verify_frame(input int g, input string tag);
    int n, bad_dat, bad_cyc;
    n = n_of(g);
    bad_dat = 0;
    bad_cyc = 0;
    for (int k = 0; k < n * n; k++) begin
      if (dst_mem[g][k] !== ref_pix(g, k)) bad_dat++;
      if (wr_cyc[g][k] != c0[g] + k + l_of(g)) bad_cyc++;
    end
    check({tag, "_data_errs"}, bad_dat, 0);
    check({tag, "_wcyc_errs"}, bad_cyc, 0);
    check({tag, "_n_writes"}, wr_cnt[g] - wr_base[g], n * n);
`ifdef UNPADDER_CHECKSUM_EN
    begin
      logic [15:0] s;
      s = '0;
      for (int k = 0; k < n * n; k++) s = s + 16'(ref_pix(g, k));
      check({tag, "_checksum"}, csum_v[g], s);
    end
`endif
  endtask

  task automatic end_frame(input int g, input string tag);
    go_v[g] = 1'b0;
    @(posedge clk); #1;
    check({tag, "_done_clr"}, done_v[g], 0);
  endtask

  task automatic fill_random();
    for (int a = 0; a < 32768; a++) src_mem[a] = 8'($urandom);
  endtask

  initial begin
    int ec, wc, same, cnt_a;
    bit saw_done;

    rst_n = 1'b0;
    for (int g = 0; g < NI; g++) go_v[g] = 1'b0;
    for (int a = 0; a < 32768; a++) src_mem[a] = 8'(a);
    repeat (3) @(posedge clk); #1;

    for (int g = 0; g < NI; g++) begin
      check($sformatf("rst%0d_done", g), done_v[g], 0);
      check($sformatf("rst%0d_ena_src", g), ena_src_v[g], 0);
      check($sformatf("rst%0d_addr_src", g), addr_src_v[g], 0);
      check($sformatf("rst%0d_ena_dst", g), ena_dst_v[g], 0);
      check($sformatf("rst%0d_wea_dst", g), wea_v[g], 0);
      check($sformatf("rst%0d_addr_dst", g), addr_dst_v[g], 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Known ramp image, N=4, RD_LAT=1.
    start_frame(0);
    wait_done(0, "n4l1", 17);
    check("n4l1_dst0", dst_mem[0][0], 18);
    check("n4l1_dst3", dst_mem[0][3], 21);
    check("n4l1_dst4", dst_mem[0][4], 26);
    check("n4l1_dst15", dst_mem[0][15], 45);
    check("n4l1_first_wr", wr_cyc[0][0] - c0[0], 1);
    verify_frame(0, "n4l1");
`ifdef UNPADDER_CHECKSUM_EN
    check("n4l1_checksum_504", csum_v[0], 504);
`endif
    end_frame(0, "n4l1");

    // Same image, RD_LAT=2.
    start_frame(1);
    wait_done(1, "n4l2", 18);
    check("n4l2_first_wr", wr_cyc[1][0] - c0[1], 2);
    verify_frame(1, "n4l2");
    same = 0;
    for (int k = 0; k < 16; k++) if (dst_mem[1][k] === dst_mem[0][k]) same++;
    check("n4l2_match_l1", same, 16);
    end_frame(1, "n4l2");

    // N=16 with go dropped at cycle 100, then a full random frame.
    fill_random();
    start_frame(2);
    repeat (100) @(posedge clk); #1;
    go_v[2] = 1'b0;
    saw_done = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done_v[2]) saw_done = 1;
    end
    check("abort_no_late_wr", (last_wr[2] - c0[2]) <= 101, 1);
    check("abort_done_low", saw_done, 0);
    check("abort_idle_ena", ena_src_v[2], 0);
    check("abort_no_wea", wea_v[2], 0);
    start_frame(2);
    wait_done(2, "n16_restart", 257);
    verify_frame(2, "n16_restart");
    end_frame(2, "n16_restart");

    // Asynchronous reset at cycle 50 of an N=16 frame.
    fill_random();
    start_frame(2);
    repeat (50) @(posedge clk); #1;
    cnt_a = wr_cnt[2];
    #2 rst_n = 1'b0;
    #1;
    check("arst_done", done_v[2], 0);
    check("arst_ena_src", ena_src_v[2], 0);
    check("arst_addr_src", addr_src_v[2], 0);
    check("arst_ena_dst", ena_dst_v[2], 0);
    check("arst_wea_dst", wea_v[2], 0);
    check("arst_addr_dst", addr_dst_v[2], 0);
    go_v[2] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_idle_ena", ena_src_v[2], 0);
    check("arst_no_wr_after", wr_cnt[2] - cnt_a, 0);
    start_frame(2);
    wait_done(2, "n16_post_rst", 257);
    verify_frame(2, "n16_post_rst");
    end_frame(2, "n16_post_rst");

    // go held through DONE must not restart; low-then-high does.
    fill_random();
    start_frame(0);
    wait_done(0, "hold1", 17);
    verify_frame(0, "hold1");
    ec = ena_cnt[0];
    wc = wr_cnt[0];
    repeat (20) @(posedge clk); #1;
    check("hold_no_ena_src", ena_cnt[0] - ec, 0);
    check("hold_no_wea", wr_cnt[0] - wc, 0);
    check("hold_done_high", done_v[0], 1);
    end_frame(0, "hold1");
    fill_random();
    start_frame(0);
    wait_done(0, "hold2", 17);
    verify_frame(0, "hold2");
    end_frame(0, "hold2");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end
endmodule
